// File: rtl/alu_request_arbiter.sv
// rtl/alu_request_arbiter.sv - round-robin arbiter sharing one vector ALU between NUM_REQ requesters
//
// Each granted request runs one complete ALU transaction: IDLE -> ISSUE -> WAIT -> DONE.
// Optional watchdog: define ALU_ARB_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT_CYCLES.
//
// Ports:
//   Clock, Reset                 clock, asynchronous active-low reset
//   iReqValid[NUM_REQ]           per-requester request
//   iReqOperation                packed opcodes, slice i belongs to requester i
//   iReqSource0/1                packed {X,Y,Z} operand rows, slice i belongs to requester i
//   oReqGrant                    one-hot owner, held ISSUE..DONE
//   oReqDone                     one-cycle completion pulse to the owner
//   oReqError                    watchdog abort flag, valid with oReqDone
//   oResultX/Y/Z                 registered ALU result
//   oBranchTaken/NotTaken        registered branch flags, valid with oReqDone
//   oALUOperation, oALUSource0/1 latched opcode and operands towards the ALU
//   oTriggerALU                  one-cycle ALU start pulse
//   iALUResultX/Y/Z              ALU result
//   iALUOutputReady              ALU result valid, honoured only in WAIT
//   iBranchTaken/NotTaken        ALU branch flags
//   oBusy                        FSM is not in IDLE
module alu_request_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int WIDTH          = 32,
  parameter int OP_WIDTH       = 6,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic [NUM_REQ-1:0]          iReqValid,
  input  logic [NUM_REQ*OP_WIDTH-1:0] iReqOperation,
  input  logic [NUM_REQ*3*WIDTH-1:0]  iReqSource0,
  input  logic [NUM_REQ*3*WIDTH-1:0]  iReqSource1,
  output logic [NUM_REQ-1:0]          oReqGrant,
  output logic [NUM_REQ-1:0]          oReqDone,
  output logic                        oReqError,
  output logic [WIDTH-1:0]            oResultX,
  output logic [WIDTH-1:0]            oResultY,
  output logic [WIDTH-1:0]            oResultZ,
  output logic                        oBranchTaken,
  output logic                        oBranchNotTaken,
  output logic [OP_WIDTH-1:0]         oALUOperation,
  output logic [3*WIDTH-1:0]          oALUSource0,
  output logic [3*WIDTH-1:0]          oALUSource1,
  output logic                        oTriggerALU,
  input  logic [WIDTH-1:0]            iALUResultX,
  input  logic [WIDTH-1:0]            iALUResultY,
  input  logic [WIDTH-1:0]            iALUResultZ,
  input  logic                        iALUOutputReady,
  input  logic                        iBranchTaken,
  input  logic                        iBranchNotTaken,
  output logic                        oBusy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int RW = 3 * WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [PW-1:0] PTR_RESET = PW'(NUM_REQ - 1);

  logic [1:0]          state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                trig_q, trig_d;
  logic [OP_WIDTH-1:0] op_q, op_d;
  logic [RW-1:0]       src0_q, src0_d;
  logic [RW-1:0]       src1_q, src1_d;
  logic [WIDTH-1:0]    res_x_q, res_x_d;
  logic [WIDTH-1:0]    res_y_q, res_y_d;
  logic [WIDTH-1:0]    res_z_q, res_z_d;
  logic                br_t_q, br_t_d;
  logic                br_nt_q, br_nt_d;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // Round-robin pick: rank k=1 is the slot right after the previous winner,
  // so the previous owner is considered last.
  logic                win_found;
  logic [PW-1:0]       win_idx;
  logic [NUM_REQ-1:0]  win_onehot;
  logic [OP_WIDTH-1:0] win_op;
  logic [RW-1:0]       win_src0;
  logic [RW-1:0]       win_src1;

  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    win_op     = '0;
    win_src0   = '0;
    win_src1   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && (i == ((int'(ptr_q) + k) % NUM_REQ)) && iReqValid[i]) begin
          win_found     = 1'b1;
          win_idx       = PW'(i);
          win_onehot[i] = 1'b1;
          win_op        = iReqOperation[i*OP_WIDTH +: OP_WIDTH];
          win_src0      = iReqSource0[i*RW +: RW];
          win_src1      = iReqSource1[i*RW +: RW];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    done_d  = '0;
    trig_d  = 1'b0;
    op_d    = op_q;
    src0_d  = src0_q;
    src1_d  = src1_q;
    res_x_d = res_x_q;
    res_y_d = res_y_q;
    res_z_d = res_z_q;
    br_t_d  = br_t_q;
    br_nt_d = br_nt_q;
`ifdef ALU_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_ISSUE;
          ptr_d   = win_idx;
          grant_d = win_onehot;
          op_d    = win_op;
          src0_d  = win_src0;
          src1_d  = win_src1;
          trig_d  = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (iALUOutputReady) begin
          state_d = S_DONE;
          done_d  = grant_q;
          res_x_d = iALUResultX;
          res_y_d = iALUResultY;
          res_z_d = iALUResultZ;
          br_t_d  = iBranchTaken;
          br_nt_d = iBranchNotTaken;
        end
`ifdef ALU_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          // Abort: report completion with an error and a clean zero result.
          state_d = S_DONE;
          done_d  = grant_q;
          err_d   = 1'b1;
          res_x_d = '0;
          res_y_d = '0;
          res_z_d = '0;
          br_t_d  = 1'b0;
          br_nt_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      ptr_q   <= PTR_RESET;
      grant_q <= '0;
      done_q  <= '0;
      trig_q  <= 1'b0;
      op_q    <= '0;
      src0_q  <= '0;
      src1_q  <= '0;
      res_x_q <= '0;
      res_y_q <= '0;
      res_z_q <= '0;
      br_t_q  <= 1'b0;
      br_nt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      trig_q  <= trig_d;
      op_q    <= op_d;
      src0_q  <= src0_d;
      src1_q  <= src1_d;
      res_x_q <= res_x_d;
      res_y_q <= res_y_d;
      res_z_q <= res_z_d;
      br_t_q  <= br_t_d;
      br_nt_q <= br_nt_d;
    end
  end

`ifdef ALU_ARB_TIMEOUT_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign oReqError = err_q;
`else
  assign oReqError = 1'b0;
`endif

  assign oReqGrant       = grant_q;
  assign oReqDone        = done_q;
  assign oResultX        = res_x_q;
  assign oResultY        = res_y_q;
  assign oResultZ        = res_z_q;
  assign oBranchTaken    = br_t_q;
  assign oBranchNotTaken = br_nt_q;
  assign oALUOperation   = op_q;
  assign oALUSource0     = src0_q;
  assign oALUSource1     = src1_q;
  assign oTriggerALU     = trig_q;
  assign oBusy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_request_arbiter.sv
// tb/tb_alu_request_arbiter.sv - scoreboard bench for alu_request_arbiter
module tb_alu_request_arbiter;

  localparam int NR  = 3;
  localparam int W   = 32;
  localparam int OPW = 6;

  localparam logic [OPW-1:0] OP_ADD = 6'h01;
  localparam logic [OPW-1:0] OP_SUB = 6'h02;
  localparam logic [OPW-1:0] OP_MUL = 6'h03;
  localparam logic [OPW-1:0] OP_BEQ = 6'h0A;
  localparam logic [OPW-1:0] OP_BNE = 6'h0B;

  typedef logic [319:0] cv_t;

  logic                Clock = 1'b0;
  logic                Reset = 1'b0;
  logic [NR-1:0]       iReqValid;
  logic [NR*OPW-1:0]   iReqOperation;
  logic [NR*3*W-1:0]   iReqSource0;
  logic [NR*3*W-1:0]   iReqSource1;
  logic [NR-1:0]       oReqGrant;
  logic [NR-1:0]       oReqDone;
  logic                oReqError;
  logic [W-1:0]        oResultX, oResultY, oResultZ;
  logic                oBranchTaken, oBranchNotTaken;
  logic [OPW-1:0]      oALUOperation;
  logic [3*W-1:0]      oALUSource0, oALUSource1;
  logic                oTriggerALU;
  logic [W-1:0]        iALUResultX, iALUResultY, iALUResultZ;
  logic                iALUOutputReady, iBranchTaken, iBranchNotTaken;
  logic                oBusy;

  alu_request_arbiter #(
    .NUM_REQ(NR), .WIDTH(W), .OP_WIDTH(OPW), .TIMEOUT_CYCLES(8)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .iReqValid(iReqValid), .iReqOperation(iReqOperation),
    .iReqSource0(iReqSource0), .iReqSource1(iReqSource1),
    .oReqGrant(oReqGrant), .oReqDone(oReqDone), .oReqError(oReqError),
    .oResultX(oResultX), .oResultY(oResultY), .oResultZ(oResultZ),
    .oBranchTaken(oBranchTaken), .oBranchNotTaken(oBranchNotTaken),
    .oALUOperation(oALUOperation), .oALUSource0(oALUSource0), .oALUSource1(oALUSource1),
    .oTriggerALU(oTriggerALU),
    .iALUResultX(iALUResultX), .iALUResultY(iALUResultY), .iALUResultZ(iALUResultZ),
    .iALUOutputReady(iALUOutputReady), .iBranchTaken(iBranchTaken),
    .iBranchNotTaken(iBranchNotTaken), .oBusy(oBusy)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    logic [NR-1:0] done;
    logic [W-1:0]  x, y, z;
    logic          bt, bnt, err;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   trig_lat;
  int   trig_cyc;
  int   prev_trig;
  int   wait_n;

  task automatic check(input string name, input cv_t act, input cv_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3*W-1:0] row(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [W-1:0] z);
    return {x, y, z};
  endfunction

  task automatic set_req(input int idx, input logic [OPW-1:0] op,
                         input logic [3*W-1:0] s0, input logic [3*W-1:0] s1);
    for (int i = 0; i < NR; i++) begin
      if (i == idx) begin
        iReqOperation[i*OPW +: OPW] = op;
        iReqSource0[i*3*W +: 3*W]   = s0;
        iReqSource1[i*3*W +: 3*W]   = s1;
      end
    end
  endtask

  task automatic push(input logic [NR-1:0] d, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] z, input logic bt, input logic bnt, input logic err);
    exp_t e;
    e.done = d; e.x = x; e.y = y; e.z = z; e.bt = bt; e.bnt = bnt; e.err = err;
    sb_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, cv_t'({oReqGrant, oReqDone, oReqError, oTriggerALU, oBusy,
                                 oBranchTaken, oBranchNotTaken}), cv_t'(0));
    check({tag, "_data"}, cv_t'({oResultX, oResultY, oResultZ, oALUOperation}), cv_t'(0));
    check({tag, "_src"}, cv_t'({oALUSource0, oALUSource1}), cv_t'(0));
  endtask

  // Acts as the ALU: waits for the trigger, answers `delay` cycles later.
  task automatic alu_respond(input string tag, input int delay, input logic [OPW-1:0] exp_op,
                             input logic [3*W-1:0] exp_s0, input logic [3*W-1:0] exp_s1,
                             input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z,
                             input logic bt, input logic bnt);
    int n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!oTriggerALU && n < 50);
    trig_lat = n;
    trig_cyc = cyc;
    check({tag, "_trigger"}, cv_t'(oTriggerALU), cv_t'(1));
    check({tag, "_op"}, cv_t'(oALUOperation), cv_t'(exp_op));
    check({tag, "_src"}, cv_t'({oALUSource0, oALUSource1}), cv_t'({exp_s0, exp_s1}));
    for (int i = 0; i < delay; i++) begin
      @(negedge Clock);
      if (i == 0) check({tag, "_trig_pulse"}, cv_t'({oTriggerALU, oBusy}), cv_t'(2'b01));
    end
    iALUResultX = x; iALUResultY = y; iALUResultZ = z;
    iBranchTaken = bt; iBranchNotTaken = bnt;
    iALUOutputReady = 1'b1;
    @(negedge Clock);
    iALUOutputReady = 1'b0;
    iALUResultX = '0; iALUResultY = '0; iALUResultZ = '0;
    iBranchTaken = 1'b0; iBranchNotTaken = 1'b0;
    check({tag, "_done_pulse"}, cv_t'(|oReqDone), cv_t'(1));
  endtask

  // Monitor: every done pulse is matched against the oldest expected response.
  initial begin
    forever begin
      @(negedge Clock);
      if (oReqDone !== '0) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", cv_t'(oReqDone), cv_t'(0));
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("mon_done", cv_t'(oReqDone), cv_t'(e.done));
          check("mon_grant", cv_t'(oReqGrant), cv_t'(e.done));
          check("mon_result", cv_t'({oResultX, oResultY, oResultZ}), cv_t'({e.x, e.y, e.z}));
          check("mon_flags", cv_t'({oBranchTaken, oBranchNotTaken, oReqError}),
                cv_t'({e.bt, e.bnt, e.err}));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    iReqValid = '0; iReqOperation = '0; iReqSource0 = '0; iReqSource1 = '0;
    iALUResultX = '0; iALUResultY = '0; iALUResultZ = '0;
    iALUOutputReady = 1'b0; iBranchTaken = 1'b0; iBranchNotTaken = 1'b0;

    // Reset state
    repeat (2) @(negedge Clock);
    check_all_zero("reset");
    Reset = 1'b1;
    @(negedge Clock);

    // Single request: ADD {1,2,3}+{4,5,6}, ALU answers 2 cycles after trigger
    set_req(0, OP_ADD, row(1, 2, 3), row(4, 5, 6));
    push(3'b001, 5, 7, 9, 1'b0, 1'b0, 1'b0);
    iReqValid = 3'b001;
    alu_respond("t1", 2, OP_ADD, row(1, 2, 3), row(4, 5, 6), 5, 7, 9, 1'b0, 1'b0);
    check("t1_trig_latency", cv_t'(trig_lat), cv_t'(1));
    iReqValid = '0;
    @(negedge Clock);
    check("t1_idle", cv_t'({oBusy, oReqGrant, oReqDone}), cv_t'(0));
    check("t1_result_hold", cv_t'({oResultX, oResultY, oResultZ}), cv_t'(row(5, 7, 9)));

    // Reset in WAIT: abort, no done; afterwards requester 0 wins over 1
    set_req(0, OP_SUB, row(50, 60, 70), row(5, 6, 7));
    iReqValid = 3'b001;
    @(negedge Clock);
    check("rst_issue", cv_t'(oTriggerALU), cv_t'(1));
    @(negedge Clock);
    check("rst_wait", cv_t'({oBusy, oReqGrant}), cv_t'({1'b1, 3'b001}));
    Reset = 1'b0;
    set_req(0, OP_ADD, row(10, 20, 30), row(1, 2, 3));
    set_req(1, OP_MUL, row(2, 3, 4), row(5, 6, 7));
    iReqValid = 3'b011;
    #1;
    check_all_zero("rst_mid");
    @(negedge Clock);
    Reset = 1'b1;

    // Contention: both held, grants alternate 0,1,0,1
    prev_trig = 0;
    for (int t = 0; t < 4; t++) begin
      int dly;
      dly = (t == 0) ? 2 : ((t == 3) ? 3 : 1);
      if (t % 2 == 0) begin
        push(3'b001, 11, 22, 33, 1'b0, 1'b0, 1'b0);
        alu_respond("rr_req0", dly, OP_ADD, row(10, 20, 30), row(1, 2, 3), 11, 22, 33, 1'b0, 1'b0);
      end else begin
        push(3'b010, 10, 18, 28, 1'b0, 1'b0, 1'b0);
        alu_respond("rr_req1", dly, OP_MUL, row(2, 3, 4), row(5, 6, 7), 10, 18, 28, 1'b0, 1'b0);
      end
      if (t == 2) check("b2b_spacing", cv_t'(trig_cyc - prev_trig), cv_t'(4));
      prev_trig = trig_cyc;
    end
    iReqValid = '0;

    // Ready outside WAIT is ignored
    @(negedge Clock);
    iALUOutputReady = 1'b1;
    iALUResultX = 32'hDEAD; iALUResultY = 32'hBEEF; iALUResultZ = 32'hF00D;
    @(negedge Clock);
    check("ready_idle", cv_t'({oBusy, oReqDone, oTriggerALU}), cv_t'(0));
    set_req(2, OP_ADD, row(7, 7, 7), row(1, 2, 3));
    iReqValid = 3'b100;
    @(negedge Clock);
    check("ready_issue", cv_t'({oTriggerALU, oReqGrant}), cv_t'({1'b1, 3'b100}));
    @(negedge Clock);
    check("ready_wait", cv_t'({oBusy, oReqDone}), cv_t'({1'b1, 3'b000}));
    check("ready_hold", cv_t'({oResultX, oResultY, oResultZ}), cv_t'(row(10, 18, 28)));
    push(3'b100, 8, 9, 10, 1'b0, 1'b0, 1'b0);
    iALUResultX = 8; iALUResultY = 9; iALUResultZ = 10;
    @(negedge Clock);
    iALUOutputReady = 1'b0;
    iALUResultX = '0; iALUResultY = '0; iALUResultZ = '0;
    iReqValid = '0;
    check("ready_done", cv_t'(oReqDone), cv_t'(3'b100));

    // Branch flags
    set_req(0, OP_BEQ, row(4, 0, 0), row(4, 0, 0));
    push(3'b001, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    iReqValid = 3'b001;
    alu_respond("br_taken", 2, OP_BEQ, row(4, 0, 0), row(4, 0, 0), 0, 0, 0, 1'b1, 1'b0);
    iReqValid = '0;
    @(negedge Clock);
    check("br_hold", cv_t'({oBranchTaken, oBranchNotTaken}), cv_t'(2'b10));
    set_req(1, OP_BNE, row(1, 0, 0), row(1, 0, 0));
    push(3'b010, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    iReqValid = 3'b010;
    alu_respond("br_not", 1, OP_BNE, row(1, 0, 0), row(1, 0, 0), 0, 0, 0, 1'b0, 1'b1);
    iReqValid = '0;
    @(negedge Clock);

`ifdef ALU_ARB_TIMEOUT_EN
    // Watchdog: ALU never ready, abort after 8 WAIT cycles (trigger cycle 1, done cycle 10)
    set_req(0, OP_ADD, row(9, 9, 9), row(1, 1, 1));
    push(3'b001, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    iALUResultX = 32'h55; iALUResultY = 32'h66; iALUResultZ = 32'h77;
    iReqValid = 3'b001;
    wait_n = 0;
    do begin
      @(negedge Clock);
      wait_n++;
    end while (!oTriggerALU && wait_n < 50);
    check("to_trigger", cv_t'(oTriggerALU), cv_t'(1));
    wait_n = 0;
    do begin
      @(negedge Clock);
      wait_n++;
    end while (oReqDone == '0 && wait_n < 40);
    check("to_latency", cv_t'(wait_n), cv_t'(9));
    iReqValid = '0;
    iALUResultX = '0; iALUResultY = '0; iALUResultZ = '0;
    @(negedge Clock);
`endif

    repeat (3) @(negedge Clock);
    check("sb_empty", cv_t'(sb_q.size()), cv_t'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_request_arbiter.md
# alu_request_arbiter

Shares the single vector ALU (three 32-bit channels per operand) between `NUM_REQ` execution requesters, e.g. the main execution FSM and an auxiliary unit. Each request runs as one complete ALU transaction: arbitrate, latch the operands, pulse the ALU trigger, wait for ALU output-ready, return the result. Arbitration is round-robin. The block sits between the requesters' ALU ports and the ALU itself; write-back stays with each requester.

## Interface
- `NUM_REQ`, default 2: number of requesters (2..8).
- `WIDTH`, default 32: channel width; operand and result rows are 3*`WIDTH`.
- `OP_WIDTH`, default 6: opcode width (`INSTRUCTION_OP_LENGTH`).
- `TIMEOUT_CYCLES`, default 255: watchdog limit. Used only with `ALU_ARB_TIMEOUT_EN`.

Ports:
- `Clock` in 1: the single clock.
- `Reset` in 1: asynchronous, active-low reset.
- `iReqValid` in `NUM_REQ`: request, one bit per requester.
- `iReqOperation` in `NUM_REQ`*`OP_WIDTH`: packed opcodes; requester i uses slice i.
- `iReqSource0`, `iReqSource1` in `NUM_REQ`*3*`WIDTH`: packed operand rows as {X,Y,Z}.
- `oReqGrant` out `NUM_REQ`: one-hot owner of the current transaction.
- `oReqDone` out `NUM_REQ`: one-cycle completion pulse to the owner.
- `oReqError` out 1: timeout abort flag, valid together with `oReqDone`.
- `oResultX`, `oResultY`, `oResultZ` out `WIDTH`: registered ALU result.
- `oBranchTaken`, `oBranchNotTaken` out 1: registered branch flags, valid with `oReqDone`.
- `oALUOperation` out `OP_WIDTH`: latched opcode.
- `oALUSource0`, `oALUSource1` out 3*`WIDTH`: latched operands.
- `oTriggerALU` out 1: one-cycle ALU start pulse.
- `iALUResultX`, `iALUResultY`, `iALUResultZ` in `WIDTH`: ALU result.
- `iALUOutputReady`, `iBranchTaken`, `iBranchNotTaken` in 1: ALU status.
- `oBusy` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE → ISSUE → WAIT → DONE → IDLE.
- **IDLE:**
  - If any `iReqValid` bit is set, pick the first set bit, searching upward from `rPtr`+1 modulo `NUM_REQ`.
  - Register the grant one-hot, and latch that requester's opcode and operands into `oALUOperation` and `oALUSource0/1`.
  - Set `rPtr` to the winner's index. Go to ISSUE.
- **ISSUE:** `oTriggerALU`=1 for exactly this cycle. Go to WAIT.
- **WAIT:**
  - On `iALUOutputReady`=1, register the X/Y/Z results and both branch flags. Go to DONE.
  - Ready is ignored in every other state.
- **DONE:** `oReqDone[g]`=1 for this cycle only. Go to IDLE.
- `oReqGrant` holds from ISSUE through DONE and is 0 in IDLE.
- Requesters hold `iReqValid` and the payload until they see `oReqDone`, then deassert on the following edge.
- `iReqValid` is sampled only in IDLE. A requester that drops valid mid-transaction does not cancel it; `oReqDone` still pulses.
- A requester that keeps valid high after done is re-arbitrated as a new request. Round-robin order still lets the others win first.
- An encoding outside the four states goes to IDLE.
- Reset values: every output is 0, FSM is in IDLE, `rPtr`=`NUM_REQ`-1, so requester 0 wins the first arbitration.
- Reset asserted mid-transaction aborts it immediately: no `oReqDone`, grant cleared.

## Timing
- Request seen in IDLE at cycle 0 → ISSUE with trigger at cycle 1 → WAIT from cycle 2.
- ALU ready at cycle k ≥ 2 → DONE at cycle k+1 → IDLE at cycle k+2.
- Minimum request-to-done latency is 3 cycles. Minimum back-to-back issue spacing is 4 cycles.
- Results and branch flags are stable from DONE until the next WAIT capture.

## Configuration
- `ALU_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments every WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` without ready, go to DONE with `oReqError`=1 and results forced to 0.
  - In all other cases `oReqError`=0.
- `ALU_ARB_TIMEOUT_EN` not defined:
  - WAIT persists indefinitely.
  - `oReqError` is tied to 0 and no counter logic is present.

## Test plan
- Single request: req0 with ADD, sources {1,2,3} and {4,5,6}; ALU returns {5,7,9} 2 cycles after trigger → `oTriggerALU` at cycle 1, `oReqDone[0]` at cycle 4 with result 5/7/9, `oReqError`=0.
- Contention: req0 and req1 both held continuously → grants alternate 0,1,0,1 over 4 transactions; every `oReqGrant` is one-hot.
- Out-of-state ready: `iALUOutputReady` pulsed in IDLE and in ISSUE → no state change; ready in WAIT completes the transaction normally.
- Branch op: ALU ready with `iBranchTaken`=1 → `oBranchTaken`=1 in the DONE cycle alongside `oReqDone`.
- Reset mid-WAIT: `Reset` low for 1 cycle → all outputs 0, no done pulse; the next request goes to requester 0.
- With `ALU_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, ALU never ready → `oReqDone` and `oReqError`=1 exactly 8 WAIT cycles after entering WAIT, result 0.
